// File: rtl/tanh_grad_pipe_if.sv
// rtl/tanh_grad_pipe_if.sv - stream and status signals of the tanh gradient pipe
// slave modport is the pipe itself; master modport is the driving side.
interface tanh_grad_pipe_if #(
  parameter int W     = 16,
  parameter int CNT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_y;
  logic [W-1:0]     s_g;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_dx;
  logic             m_oor;
  logic [CNT_W-1:0] oor_cnt;

  modport slave (
    input  s_valid, s_y, s_g, m_ready,
    output s_ready, m_valid, m_dx, m_oor, oor_cnt
  );

  modport master (
    output s_valid, s_y, s_g, m_ready,
    input  s_ready, m_valid, m_dx, m_oor, oor_cnt
  );
endinterface

// File: rtl/tanh_grad_pipe.sv
// rtl/tanh_grad_pipe.sv - 2-stage pipe computing dx = g*(1-y*y), signed Q6.9
// TANH_GRAD_ROUND_EN selects round-half-up shifts instead of truncation.
module tanh_grad_pipe #(
  parameter int W     = 16,
  parameter int FRAC  = 9,
  parameter int CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  tanh_grad_pipe_if.slave    bus
);
  localparam int SQW = 2 * W;
  localparam logic [FRAC:0]            ONE    = {1'b1, {FRAC{1'b0}}};
  localparam logic signed [W-1:0]      ONE_W  = W'(ONE);
  localparam logic signed [W-1:0]      NONE_W = -ONE_W;
  localparam logic [SQW-1:0]           ONE_SQ = SQW'(ONE);
  localparam int                       HALF_I = 1 << (FRAC - 1);
  localparam logic signed [SQW-1:0]    HALF   = SQW'(HALF_I);

  logic             adv1, adv2, s_fire;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [FRAC:0]    d1_q, d1_d;
  logic [W-1:0]     g1_q, g1_d;
  logic             oor1_q, oor1_d;
  logic [W-1:0]     dx2_q, dx2_d;
  logic             oor2_q, oor2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [SQW-1:0] y_ext, sq, sq_r;
  logic        [SQW-1:0] y2;
  logic signed [SQW-1:0] g_ext, d_ext, p, p_r;
  logic                  oor_now;
  logic [FRAC:0]         d_now;

  assign adv2        = !v2_q || bus.m_ready;
  assign adv1        = !v1_q || adv2;
  assign s_fire      = bus.s_valid && adv1;
  assign bus.s_ready = adv1;
  assign bus.m_valid = v2_q;
  assign bus.m_dx    = dx2_q;
  assign bus.m_oor   = oor2_q;
  assign bus.oor_cnt = cnt_q;

  // Stage 1 arithmetic: 1 - y^2, clamped to zero once y^2 reaches ONE
  always_comb begin
    y_ext   = {{W{bus.s_y[W-1]}}, bus.s_y};
    sq      = y_ext * y_ext;
`ifdef TANH_GRAD_ROUND_EN
    sq_r    = sq + HALF;
`else
    sq_r    = sq;
`endif
    y2      = $unsigned(sq_r >>> FRAC);
    oor_now = ($signed(bus.s_y) > ONE_W) || ($signed(bus.s_y) < NONE_W);
    d_now   = (y2 >= ONE_SQ) ? '0 : (ONE - y2[FRAC:0]);
  end

  // Stage 2 arithmetic: d is non-negative, so it is zero-extended before the multiply
  always_comb begin
    g_ext = {{W{g1_q[W-1]}}, g1_q};
    d_ext = {{(SQW-FRAC-1){1'b0}}, d1_q};
    p     = g_ext * d_ext;
`ifdef TANH_GRAD_ROUND_EN
    p_r   = p + HALF;
`else
    p_r   = p;
`endif
  end

  always_comb begin
    v1_d   = v1_q;
    d1_d   = d1_q;
    g1_d   = g1_q;
    oor1_d = oor1_q;
    v2_d   = v2_q;
    dx2_d  = dx2_q;
    oor2_d = oor2_q;
    cnt_d  = cnt_q;
    if (adv1) begin
      v1_d = bus.s_valid;
    end
    if (s_fire) begin
      d1_d   = d_now;
      g1_d   = bus.s_g;
      oor1_d = oor_now;
      if (oor_now && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        dx2_d  = W'(p_r >>> FRAC);
        oor2_d = oor1_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      g1_q   <= '0;
      oor1_q <= 1'b0;
      v2_q   <= 1'b0;
      dx2_q  <= '0;
      oor2_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      d1_q   <= d1_d;
      g1_q   <= g1_d;
      oor1_q <= oor1_d;
      v2_q   <= v2_d;
      dx2_q  <= dx2_d;
      oor2_q <= oor2_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tanh_grad_pipe.sv
// tb/tb_tanh_grad_pipe.sv - directed table-driven bench for tanh_grad_pipe
// Expected values are hand-computed Q6.9 results for both rounding builds.
module tb_tanh_grad_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tanh_grad_pipe_if #(.W(16), .CNT_W(8)) bus ();

  tanh_grad_pipe #(.W(16), .FRAC(9), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] y;
    logic [15:0] g;
    logic [15:0] dx;
    logic        oor;
  } vec_t;

  vec_t        vt [11];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_one(input vec_t v, input int idx);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_y     = v.y;
    bus.s_g     = v.g;
    bus.m_ready = 1'b1;
    #1 chk($sformatf("v%0d_s_ready", idx), 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk($sformatf("v%0d_early_valid", idx), 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_m_valid", idx), 32'(bus.m_valid), 32'd1);
    chk($sformatf("v%0d_m_dx", idx), 32'(bus.m_dx), 32'(v.dx));
    chk($sformatf("v%0d_m_oor", idx), 32'(bus.m_oor), 32'(v.oor));
    if (v.oor && exp_cnt < 255) exp_cnt++;
    chk($sformatf("v%0d_oor_cnt", idx), 32'(bus.oor_cnt), 32'(exp_cnt));
  endtask

  initial begin
    vt[0]  = '{16'h0100, 16'h0200, 16'h0180, 1'b0};
    vt[1]  = '{16'h0000, 16'hFE00, 16'hFE00, 1'b0};
    vt[2]  = '{16'h0200, 16'h7FFF, 16'h0000, 1'b0};
    vt[3]  = '{16'h0300, 16'h0200, 16'h0000, 1'b1};
    vt[4]  = '{16'h8000, 16'h0200, 16'h0000, 1'b1};
    vt[5]  = '{16'hFF00, 16'h0400, 16'h0300, 1'b0};
    vt[6]  = '{16'h0100, 16'hFFFF, 16'hFFFF, 1'b0};
    vt[7]  = '{16'h0080, 16'h0200, 16'h01E0, 1'b0};
    vt[8]  = '{16'h0201, 16'h0200, 16'h0000, 1'b1};
`ifdef TANH_GRAD_ROUND_EN
    vt[9]  = '{16'h0010, 16'h7FFF, 16'h7FBF, 1'b0};
`else
    vt[9]  = '{16'h0010, 16'h7FFF, 16'h7FFF, 1'b0};
`endif
    vt[10] = '{16'hFE00, 16'h1234, 16'h0000, 1'b0};

    bus.s_valid = 1'b0;
    bus.s_y     = '0;
    bus.s_g     = '0;
    bus.m_ready = 1'b1;
    rst         = 1'b1;
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_dx", 32'(bus.m_dx), 32'd0);
    chk("rst_m_oor", 32'(bus.m_oor), 32'd0);
    chk("rst_oor_cnt", 32'(bus.oor_cnt), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) send_one(vt[i], i);

    // saturation of the out-of-range counter
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_y     = 16'h0300;
    bus.s_g     = 16'h0200;
    bus.m_ready = 1'b1;
    repeat (254) @(negedge clk);
    chk("sat_cnt_254", 32'(bus.oor_cnt), 32'd254);
    repeat (46) @(negedge clk);
    chk("sat_cnt_300", 32'(bus.oor_cnt), 32'd255);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_cnt_hold", 32'(bus.oor_cnt), 32'd255);

    // 8-beat stream with a 3-cycle downstream stall
    begin
      int          in_i = 0;
      int          out_i = 0;
      int          cyc = 0;
      bit          saw_low = 1'b0;
      bit          prev_stall = 1'b0;
      logic [15:0] held_dx = '0;
      logic        held_oor = 1'b0;
      while (out_i < 8 && cyc < 100) begin
        @(negedge clk);
        bus.m_ready = !(cyc >= 4 && cyc <= 6);
        if (in_i < 8) begin
          bus.s_valid = 1'b1;
          bus.s_y     = vt[in_i].y;
          bus.s_g     = vt[in_i].g;
        end else begin
          bus.s_valid = 1'b0;
        end
        #1;
        if (!bus.s_ready) saw_low = 1'b1;
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.m_valid), 32'd1);
          chk("stall_dx", 32'(bus.m_dx), 32'(held_dx));
          chk("stall_oor", 32'(bus.m_oor), 32'(held_oor));
        end
        if (bus.m_valid && bus.m_ready) begin
          chk($sformatf("stream%0d_dx", out_i), 32'(bus.m_dx), 32'(vt[out_i].dx));
          chk($sformatf("stream%0d_oor", out_i), 32'(bus.m_oor), 32'(vt[out_i].oor));
          out_i++;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        held_dx    = bus.m_dx;
        held_oor   = bus.m_oor;
        if (bus.s_valid && bus.s_ready) in_i++;
        cyc++;
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      chk("stream_out_count", 32'(out_i), 32'd8);
      chk("stream_in_count", 32'(in_i), 32'd8);
      chk("stream_sready_drop", 32'(saw_low), 32'd1);
      @(negedge clk);
      chk("stream_drained", 32'(bus.m_valid), 32'd0);
    end

    // reset with two beats in flight
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_y     = 16'h0300;
    bus.s_g     = 16'h0200;
    repeat (2) @(negedge clk);
    bus.s_valid = 1'b0;
    chk("flight_m_valid", 32'(bus.m_valid), 32'd1);
    chk("flight_s_ready", 32'(bus.s_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_oor_cnt", 32'(bus.oor_cnt), 32'd0);
    chk("midrst_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = 0;
    send_one(vt[0], 100);
    @(negedge clk);
    chk("post_rst_empty", 32'(bus.m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
